mont_res_reducer: RTL

MONT_RES_REDUCER -- requirements
Module: mont_res_reducer

---
 rtl/mont_res_reducer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mont_res_reducer.sv
// Conditional final subtraction for two Montgomery results sharing one modulus:
// streams res_k and p digit-serially, keeps res and res-p, then selects by the final borrow.
module mont_res_reducer #(
    parameter int RADIX     = 64,
    parameter int WIDTH     = 6,
    parameter int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mult_0_mem_res_rd_en,
    output logic [WIDTH_LOG-1:0] mult_0_mem_res_rd_addr,
    input  logic [RADIX-1:0]     mult_0_mem_res_dout,
    output logic                 mult_1_mem_res_rd_en,
    output logic [WIDTH_LOG-1:0] mult_1_mem_res_rd_addr,
    input  logic [RADIX-1:0]     mult_1_mem_res_dout,
    output logic                 mem_p_rd_en,
    output logic [WIDTH_LOG-1:0] mem_p_rd_addr,
    input  logic [RADIX-1:0]     mem_p_dout,
    input  logic                 out_0_rd_en,
    input  logic [WIDTH_LOG-1:0] out_0_rd_addr,
    output logic [RADIX-1:0]     out_0_dout,
    input  logic                 out_1_rd_en,
    input  logic [WIDTH_LOG-1:0] out_1_rd_addr,
    output logic [RADIX-1:0]     out_1_dout,
    output logic [1:0]           o_dbg_state
);

    localparam int DEPTH = 1 << WIDTH_LOG;
    localparam logic [WIDTH_LOG-1:0] LAST = WIDTH_LOG'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                 w_rd_en;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_start_acc;
    logic [WIDTH_LOG-1:0] r_addr;
    logic                 r_cap_vld;
    logic [WIDTH_LOG-1:0] r_cap_addr;

    logic [RADIX-1:0]     w_res_dout [2];
    logic                 w_out_en   [2];
    logic [WIDTH_LOG-1:0] w_out_addr [2];
    logic [RADIX:0]       w_sub      [2];
    logic [RADIX-1:0]     w_diff     [2];
    logic [1:0]           w_borrow;
    logic [1:0]           r_borrow;
    logic [1:0]           r_sel;
    logic [RADIX-1:0]     r_out      [2];
    logic [RADIX-1:0]     r_res_buf  [2][DEPTH];
    logic [RADIX-1:0]     r_diff_buf [2][DEPTH];

    assign w_res_dout[0] = mult_0_mem_res_dout;
    assign w_res_dout[1] = mult_1_mem_res_dout;
    assign w_out_en[0]   = out_0_rd_en;
    assign w_out_en[1]   = out_1_rd_en;
    assign w_out_addr[0] = out_0_rd_addr;
    assign w_out_addr[1] = out_1_rd_addr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FINISH lasts two cycles: the last digit subtract, then the done cycle once capture drains.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_READ;
            end
            S_READ: begin
                w_rd_en = 1'b1;
                w_busy  = 1'b1;
                if (r_addr == LAST) w_state_nxt = S_FINISH;
            end
            S_FINISH: begin
                w_busy = 1'b1;
                if (!r_cap_vld) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_start_acc = (r_state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_addr <= '0;
        end else begin
            if (w_rd_en) r_addr <= (r_addr == LAST) ? '0 : r_addr + 1'b1;
            r_cap_vld  <= w_rd_en;
            r_cap_addr <= r_addr;
        end
    end

    // Digit subtract with one extra bit: the top bit is the outgoing borrow.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_sub[k]    = {1'b0, w_res_dout[k]} - {1'b0, mem_p_dout}
                        - {{RADIX{1'b0}}, r_borrow[k]};
            w_diff[k]   = w_sub[k][RADIX-1:0];
            w_borrow[k] = w_sub[k][RADIX];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_borrow <= '0;
            r_sel    <= '0;
        end else if (w_start_acc) begin
            r_borrow <= '0;
        end else if (r_cap_vld) begin
            r_borrow <= w_borrow;
            if (r_cap_addr == LAST) r_sel <= w_borrow;
        end
    end

    always_ff @(posedge clk) begin
        if (r_cap_vld) begin
            for (int k = 0; k < 2; k++) begin
                r_res_buf[k][r_cap_addr]  <= w_res_dout[k];
                r_diff_buf[k][r_cap_addr] <= w_diff[k];
            end
        end
    end

    // A set borrow means res < p, so the untouched res is the reduced value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out[0] <= '0;
            r_out[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_out_en[k]) begin
                    r_out[k] <= r_sel[k] ? r_res_buf[k][w_out_addr[k]]
                                         : r_diff_buf[k][w_out_addr[k]];
                end
            end
        end
    end

    assign busy                   = w_busy;
    assign done                   = w_done;
    assign mult_0_mem_res_rd_en   = w_rd_en;
    assign mult_1_mem_res_rd_en   = w_rd_en;
    assign mem_p_rd_en            = w_rd_en;
    assign mult_0_mem_res_rd_addr = r_addr;
    assign mult_1_mem_res_rd_addr = r_addr;
    assign mem_p_rd_addr          = r_addr;
    assign out_0_dout             = r_out[0];
    assign out_1_dout             = r_out[1];
    assign o_dbg_state            = r_state;

endmodule
